// File: rtl/ahb_sram_ctrl_pkg.sv
// Shared AHB definitions for the SRAM controller: transfer encodings,
// default geometry, error-response state type and byte-lane decode.
package ahb_sram_ctrl_pkg;

   localparam int DEFAULT_DEPTH = 3072;
   localparam int DEFAULT_AW    = 12;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'd0,
      HSIZE_HALF = 3'd1,
      HSIZE_WORD = 3'd2
   } hsize_t;

   // Two-cycle ERROR response sequencer.
   typedef enum logic [1:0] {
      ERR_IDLE,
      ERR_FIRST,
      ERR_SECOND
   } err_state_t;

   // Byte lanes touched by a transfer of the given size at the given offset.
   function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] offset);
      case (size)
         HSIZE_BYTE: return 4'b0001 << offset;
         HSIZE_HALF: return 4'b0011 << {offset[1], 1'b0};
         default:    return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/ahb_sram_wbuf.sv
// One-entry write buffer: holds a write that lost the SRAM port to a read,
// and merges its lanes into read data that targets the same word.
module ahb_sram_wbuf
   import ahb_sram_ctrl_pkg::*;
#(
   parameter int AW = DEFAULT_AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          commit,
   input  logic [AW-1:0] load_addr,
   input  logic [3:0]    load_lanes,
   input  logic [31:0]   load_data,
   input  logic [AW-1:0] rd_addr,
   input  logic [31:0]   sram_rdata,
   output logic          valid,
   output logic [AW-1:0] addr,
   output logic [3:0]    lanes,
   output logic [31:0]   data,
   output logic [31:0]   rd_data
);

   logic hit;

   // Valid flag: set on load, cleared once the entry reaches the SRAM.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      if (!rst_n)
         valid <= 1'b0;
      else if (load)
         valid <= 1'b1;
      else if (commit)
         valid <= 1'b0;
   end

   // Payload capture; only meaningful while valid is set.
   always_ff @(posedge clk) begin
      // NOTE: payload is deliberately not reset -- valid alone qualifies it, saving reset fan-out.
      if (load) begin
         addr  <= load_addr;
         lanes <= load_lanes;
         data  <= load_data;
      end
   end

   assign hit = valid && (addr == rd_addr);

   // Read merge: buffered lanes override stale SRAM bytes for the same word.
   always_comb begin
      // NOTE: assign a default first so no path leaves rd_data unassigned (no latch).
      rd_data = sram_rdata;
      for (int i = 0; i < 4; i++) begin
         if (hit && lanes[i])
            rd_data[8*i +: 8] = data[8*i +: 8];
      end
   end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave in front of a single-port 32-bit SRAM. Reads and writes are
// zero-wait; a write whose data phase collides with a read is parked in a
// one-entry buffer and committed when the port is next idle.
module ahb_sram_ctrl
   import ahb_sram_ctrl_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = DEFAULT_AW
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          HSEL,
   input  logic [31:0]   HADDR,
   input  logic [1:0]    HTRANS,
   input  logic          HWRITE,
   input  logic [2:0]    HSIZE,
   input  logic [31:0]   HWDATA,
   input  logic          HREADY,
   output logic          HREADYOUT,
   output logic          HRESP,
   output logic [31:0]   HRDATA,
   input  logic [31:0]   SRAMRDATA,
   output logic [3:0]    SRAMWEN,
   output logic [31:0]   SRAMWDATA,
   output logic          SRAMCS0,
   output logic [AW-1:0] SRAMADDR
);

   localparam logic [AW:0] DEPTH_LIMIT = DEPTH[AW:0];

   logic [AW-1:0] word_addr;
   logic [3:0]    lanes;
   logic          accept, bad_xfer, err_xfer, rd_acc, wr_acc;
   logic          out_of_range, bad_size, misaligned;
   logic          wr_dp, rd_dp;
   logic [AW-1:0] dp_addr;
   logic [3:0]    dp_lanes;
   logic          buf_load, buf_commit, buf_valid;
   logic [AW-1:0] buf_addr;
   logic [3:0]    buf_lanes;
   logic [31:0]   buf_data;
   err_state_t    err_state;
   logic          hreadyout_q, hresp_q;
   logic          unused_ok;

   assign word_addr    = HADDR[AW+1:2];
   assign lanes        = byte_lanes(HSIZE, HADDR[1:0]);
   assign out_of_range = ({1'b0, word_addr} >= DEPTH_LIMIT);
   assign bad_size     = (HSIZE > HSIZE_WORD);
   assign misaligned   = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                         ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
   assign bad_xfer     = out_of_range || bad_size || misaligned;
   assign accept       = HSEL && HREADY && HTRANS[1];
   assign err_xfer     = accept && bad_xfer;
   assign rd_acc       = accept && !bad_xfer && !HWRITE;
   assign wr_acc       = accept && !bad_xfer && HWRITE;
   assign unused_ok    = ^{HADDR[31:AW+2], HTRANS[0]};

   // Data-phase bookkeeping: which kind of transfer is completing and where.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         wr_dp    <= 1'b0;
         rd_dp    <= 1'b0;
         dp_addr  <= '0;
         dp_lanes <= '0;
      end else begin
         wr_dp <= wr_acc;
         rd_dp <= rd_acc;
         if (accept) begin
            dp_addr  <= word_addr;
            dp_lanes <= lanes;
         end
      end
   end

   // SRAM port arbitration: read address phase, then write data phase, then buffer.
   always_comb begin
      SRAMCS0    = 1'b0;
      SRAMWEN    = 4'b0000;
      SRAMADDR   = word_addr;
      SRAMWDATA  = HWDATA;
      buf_load   = 1'b0;
      buf_commit = 1'b0;
      if (rd_acc) begin
         SRAMCS0  = 1'b1;
         buf_load = wr_dp;
      end else if (wr_dp) begin
         SRAMCS0  = 1'b1;
         SRAMWEN  = dp_lanes;
         SRAMADDR = dp_addr;
      end else if (buf_valid) begin
         SRAMCS0    = 1'b1;
         SRAMWEN    = buf_lanes;
         SRAMADDR   = buf_addr;
         SRAMWDATA  = buf_data;
         buf_commit = 1'b1;
      end
   end

   // Error response FSM with registered HREADYOUT/HRESP.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         err_state   <= ERR_IDLE;
         hreadyout_q <= 1'b1;
         hresp_q     <= 1'b0;
      end else begin
         case (err_state)
            ERR_FIRST: begin
               err_state   <= ERR_SECOND;
               hreadyout_q <= 1'b1;
               hresp_q     <= 1'b1;
            end
            default: begin
               if (err_xfer) begin
                  err_state   <= ERR_FIRST;
                  hreadyout_q <= 1'b0;
                  hresp_q     <= 1'b1;
               end else begin
                  err_state   <= ERR_IDLE;
                  hreadyout_q <= 1'b1;
                  hresp_q     <= 1'b0;
               end
            end
         endcase
      end
   end

   assign HREADYOUT = hreadyout_q;
   assign HRESP     = hresp_q;

   ahb_sram_wbuf #(.AW(AW)) u_wbuf (
      .clk        (HCLK),
      .rst_n      (HRESETn),
      .load       (buf_load),
      .commit     (buf_commit),
      .load_addr  (dp_addr),
      .load_lanes (dp_lanes),
      .load_data  (HWDATA),
      .rd_addr    (dp_addr),
      .sram_rdata (SRAMRDATA),
      .valid      (buf_valid),
      .addr       (buf_addr),
      .lanes      (buf_lanes),
      .data       (buf_data),
      .rd_data    (HRDATA)
   );

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Self-checking bench for ahb_sram_ctrl: SRAM behavioural model, reference
// memory scoreboard for read data, and a response model for HREADYOUT/HRESP.
module tb_ahb_sram_ctrl;
   import ahb_sram_ctrl_pkg::*;

   localparam int DEPTH = 3072;
   localparam int AW    = 12;

   logic          HCLK = 1'b0;
   logic          HRESETn;
   logic          HSEL;
   logic [31:0]   HADDR;
   logic [1:0]    HTRANS;
   logic          HWRITE;
   logic [2:0]    HSIZE;
   logic [31:0]   HWDATA;
   logic          HREADY;
   logic          HREADYOUT;
   logic          HRESP;
   logic [31:0]   HRDATA;
   logic [31:0]   SRAMRDATA;
   logic [3:0]    SRAMWEN;
   logic [31:0]   SRAMWDATA;
   logic          SRAMCS0;
   logic [AW-1:0] SRAMADDR;

   always #5 HCLK = ~HCLK;

   ahb_sram_ctrl #(.DEPTH(DEPTH), .AW(AW)) u_dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HWDATA    (HWDATA),
      .HREADY    (HREADY),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP),
      .HRDATA    (HRDATA),
      .SRAMRDATA (SRAMRDATA),
      .SRAMWEN   (SRAMWEN),
      .SRAMWDATA (SRAMWDATA),
      .SRAMCS0   (SRAMCS0),
      .SRAMADDR  (SRAMADDR)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural SRAM: read data appears the cycle after chip select.
   logic [31:0] sram [0:DEPTH-1] = '{default: 32'h0};
   always @(posedge HCLK) begin
      if (SRAMCS0) begin
         if (SRAMWEN == 4'b0000)
            SRAMRDATA <= sram[SRAMADDR];
         else
            for (int i = 0; i < 4; i++)
               if (SRAMWEN[i]) sram[SRAMADDR][8*i +: 8] <= SRAMWDATA[8*i +: 8];
      end
   end

   function automatic bit tb_bad(input logic [31:0] a, input logic [2:0] sz);
      int word;
      word = int'(a[13:2]);
      return (word >= DEPTH) || (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
   endfunction

   function automatic logic [3:0] tb_lanes(input logic [2:0] sz, input logic [1:0] off);
      if (sz == 3'd0) return 4'b0001 << off;
      if (sz == 3'd1) return off[1] ? 4'b1100 : 4'b0011;
      return 4'b1111;
   endfunction

   // Reference model: memory as seen by the bus, error sequencing, expected reads.
   logic [31:0]   ref_mem [0:DEPTH-1] = '{default: 32'h0};
   logic [31:0]   rd_q [$];
   int            e_state = 0;
   bit            wp_valid = 0;
   logic [AW-1:0] wp_addr;
   logic [3:0]    wp_lanes;
   bit            rd_dp_tb = 0;
   bit            wr_dp_tb = 0;
   logic          exp_ready = 1'b1;
   logic          exp_resp = 1'b0;
   bit            restore_en = 0;
   logic [AW-1:0] restore_addr = '0;
   logic [31:0]   restore_val = '0;

   assign HREADY = exp_ready;

   always @(posedge HCLK) begin
      bit acc;
      acc = HRESETn && HSEL && HREADY && HTRANS[1];
      if (!HRESETn) begin
         e_state  = 0;
         wp_valid = 0;
         rd_dp_tb = 0;
         wr_dp_tb = 0;
      end else begin
         if (restore_en) ref_mem[restore_addr] = restore_val;
         if (wp_valid)
            for (int b = 0; b < 4; b++)
               if (wp_lanes[b]) ref_mem[wp_addr][8*b +: 8] = HWDATA[8*b +: 8];
         wp_valid = 0;
         rd_dp_tb = 0;
         wr_dp_tb = 0;
         if (e_state == 1)                       e_state = 2;
         else if (acc && tb_bad(HADDR, HSIZE))   e_state = 1;
         else                                    e_state = 0;
         if (acc && !tb_bad(HADDR, HSIZE)) begin
            if (HWRITE) begin
               wp_valid = 1;
               wp_addr  = HADDR[13:2];
               wp_lanes = tb_lanes(HSIZE, HADDR[1:0]);
               wr_dp_tb = 1;
            end else begin
               rd_q.push_back(ref_mem[HADDR[13:2]]);
               rd_dp_tb = 1;
            end
         end
      end
      exp_ready <= (e_state != 1);
      exp_resp  <= (e_state != 0);
   end

   // Mid-cycle monitor.
   bit            mon_en = 0;
   bit            port_chk = 0;
   logic [3:0]    port_wen = '0;
   logic [AW-1:0] port_addr = '0;
   bit            no_cs_chk = 0;

   always @(negedge HCLK) begin
      if (mon_en) begin
         check("hreadyout", HREADYOUT, exp_ready);
         check("hresp", HRESP, exp_resp);
         if (rd_dp_tb) begin
            if (rd_q.size() == 0) check("rd_q_size", 32'(rd_q.size()), 32'd1);
            else                  check("hrdata", HRDATA, rd_q.pop_front());
         end
         if (wr_dp_tb)
            check("wbuf_single_entry", u_dut.u_wbuf.valid, 1'b0);
         if (HRESETn && HSEL && HREADY && HTRANS[1] && !HWRITE && !tb_bad(HADDR, HSIZE)) begin
            check("rd_cs", SRAMCS0, 1'b1);
            check("rd_wen", SRAMWEN, 4'b0000);
            check("rd_addr", SRAMADDR, HADDR[13:2]);
         end
         if (port_chk) begin
            check("port_cs", SRAMCS0, 1'b1);
            check("port_wen", SRAMWEN, port_wen);
            check("port_addr", SRAMADDR, port_addr);
         end
         if (no_cs_chk)
            check("no_sram_access", SRAMCS0, 1'b0);
      end
   end

   // One bus cycle: drive address-phase fields and data-phase HWDATA.
   task automatic drive(input bit sel, input bit wr, input logic [31:0] addr,
                        input logic [2:0] sz, input logic [31:0] wdata);
      HSEL   = sel;
      HTRANS = sel ? HTRANS_NONSEQ : HTRANS_IDLE;
      HWRITE = wr;
      HADDR  = addr;
      HSIZE  = sz;
      HWDATA = wdata;
      @(posedge HCLK);
      #1;
   endtask

   task automatic idle(input logic [31:0] wdata);
      drive(1'b0, 1'b0, 32'h0, 3'd0, wdata);
   endtask

   task automatic expect_port(input logic [3:0] wen, input logic [AW-1:0] a);
      port_chk  = 1;
      port_wen  = wen;
      port_addr = a;
   endtask

   initial begin
      HRESETn = 1'b0;
      HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
      HADDR = '0; HSIZE = '0; HWDATA = '0;
      repeat (3) @(posedge HCLK);
      #1;
      check("rst_hreadyout", HREADYOUT, 1'b1);
      check("rst_hresp", HRESP, 1'b0);
      check("rst_cs", SRAMCS0, 1'b0);
      check("rst_wen", SRAMWEN, 4'b0000);
      check("rst_wbuf_valid", u_dut.u_wbuf.valid, 1'b0);
      HRESETn = 1'b1;
      mon_en  = 1;

      // Word write then read back.
      drive(1, 1, 32'h10, 3'd2, 32'h0);
      expect_port(4'b1111, 12'h004);
      idle(32'hDEADBEEF);
      port_chk = 0;
      drive(1, 0, 32'h10, 3'd2, 32'h0);
      idle(32'h0);

      // Write immediately followed by read of the same word: buffer + merge + commit.
      drive(1, 1, 32'h20, 3'd2, 32'h0);
      drive(1, 0, 32'h20, 3'd2, 32'h11223344);
      expect_port(4'b1111, 12'h008);
      idle(32'h0);
      port_chk = 0;
      idle(32'h0);

      // Byte write into lane 1 with an immediate word read.
      drive(1, 1, 32'h30, 3'd2, 32'h0);
      idle(32'h00000000);
      drive(1, 1, 32'h31, 3'd0, 32'h0);
      drive(1, 0, 32'h30, 3'd2, 32'h0000AA00);
      idle(32'h0);
      idle(32'h0);

      // Out-of-range read: two-cycle ERROR, no SRAM access.
      no_cs_chk = 1;
      drive(1, 0, 32'h3000, 3'd2, 32'h0);
      idle(32'h0);
      idle(32'h0);
      no_cs_chk = 0;

      // Misaligned halfword write, then a valid read right in the second error cycle.
      drive(1, 1, 32'h40, 3'd2, 32'h0);
      idle(32'hCAFEF00D);
      no_cs_chk = 1;
      drive(1, 1, 32'h41, 3'd1, 32'h0);
      idle(32'hFFFFFFFF);
      no_cs_chk = 0;
      drive(1, 0, 32'h40, 3'd2, 32'h0);
      idle(32'h0);
      idle(32'h0);

      // Reset while the buffer holds an uncommitted write.
      drive(1, 1, 32'h50, 3'd2, 32'h0);
      idle(32'h55555555);
      idle(32'h0);
      drive(1, 1, 32'h50, 3'd2, 32'h0);
      drive(1, 0, 32'h60, 3'd2, 32'h66666666);
      check("wbuf_loaded", u_dut.u_wbuf.valid, 1'b1);
      HRESETn = 1'b0;
      drive(1, 0, 32'h60, 3'd2, 32'h0);
      HRESETn = 1'b1;
      check("post_rst_wbuf_valid", u_dut.u_wbuf.valid, 1'b0);
      restore_addr = 12'h014;
      restore_val  = 32'h55555555;
      restore_en   = 1;
      idle(32'h0);
      restore_en = 0;
      drive(1, 0, 32'h50, 3'd2, 32'h0);
      idle(32'h0);

      // Mixed random traffic over a few words, including error transfers.
      for (int i = 0; i < 120; i++) begin
         int          op;
         logic [31:0] a;
         logic [2:0]  sz;
         op = $urandom_range(0, 9);
         sz = 3'($urandom_range(0, 2));
         a  = 32'h100 + 32'($urandom_range(0, 3) << 2);
         if (sz == 3'd0) a[1:0] = 2'($urandom_range(0, 3));
         if (sz == 3'd1) a[1]   = 1'($urandom_range(0, 1));
         if (!HREADY || op < 2)
            idle($urandom);
         else if (op < 5)
            drive(1, 0, a, sz, $urandom);
         else if (op < 9)
            drive(1, 1, a, sz, $urandom);
         else
            drive(1, op[0], (op[1] ? 32'h3004 : a | 32'h1), 3'd2, $urandom);
      end
      repeat (4) idle(32'h0);

      check("rd_q_drained", 32'(rd_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_sram_ctrl.md
AHB_SRAM_CTRL -- requirements
Module: ahb_sram_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 3072, meaning the number of 32-bit SRAM words.
REQ-002 SHALL have parameter AW, default 12, meaning the SRAM word-address width.
REQ-003 SHALL have these ports:
- HCLK  in  1  single clock
- HRESETn  in  1  reset, synchronous, active-low
- HSEL  in  1  slave select
- HADDR  in  32  byte address
- HTRANS  in  2  transfer type
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size
- HWDATA  in  32  write data
- HREADY  in  1  bus ready
- HREADYOUT  out  1  slave ready
- HRESP  out  1  1 = ERROR
- HRDATA  out  32  read data
- SRAMRDATA  in  32  SRAM read data, valid the cycle after CS
- SRAMWEN  out  4  per-byte write enable
- SRAMWDATA  out  32  SRAM write data
- SRAMCS0  out  1  SRAM enable
- SRAMADDR  out  AW  SRAM word address

Function
REQ-004 SHALL accept an address phase only when HSEL & HREADY & HTRANS[1]; IDLE/BUSY SHALL get zero-wait OKAY with no SRAM access.
REQ-005 SHALL decode byte lanes as follows: HSIZE=0 -> 4'b0001<<HADDR[1:0]; HSIZE=1 -> 4'b0011<<{HADDR[1],1'b0}; HSIZE=2 -> 4'b1111.
REQ-006 SHALL treat any of the following as an error transfer: HADDR[AW+1:2] >= DEPTH; HSIZE > 2; HSIZE=1 with HADDR[0]=1; HSIZE=2 with HADDR[1:0]!=0.
REQ-007 SHALL respond to an error transfer with two cycles (HREADYOUT=0,HRESP=1 then HREADYOUT=1,HRESP=1), perform no SRAM access, and leave the buffer untouched.
REQ-008 SHALL complete reads with zero wait states: SRAMCS0=1, SRAMWEN=0 and SRAMADDR=HADDR[AW+1:2] combinationally in the address-phase cycle; HRDATA SHALL be valid in the following cycle.
REQ-009 SHALL latch the address, lanes and HWRITE of a write address phase and complete the write in the data phase with HREADYOUT=1 (zero wait).
REQ-010 SHALL arbitrate the SRAM port each cycle with priority: 1) accepted read address phase; 2) current write data phase; 3) pending buffered write.
REQ-011 SHALL, when a write data phase loses arbitration to a read, store {word address, lanes, HWDATA} in a one-entry write buffer and set its valid flag.
REQ-012 SHALL commit the buffered write (SRAMCS0=1, SRAMWEN=lanes) in the first cycle the port is free, then clear valid.
REQ-013 SHALL never require a second buffer entry: the cycle before any write data phase holds a write address phase, which frees the port, so the buffer is empty on arrival; the bench SHALL assert this invariant.
REQ-014 SHALL, in a read data phase whose word address equals a valid buffered address, return HRDATA with the buffered lanes taken from the buffer and all other lanes from SRAMRDATA; this includes a read issued in the same cycle as the write data phase that filled the buffer.
REQ-015 SHALL keep HREADYOUT=1 and HRESP=0 for every non-error transfer.

Reset
REQ-016 SHALL, on HRESETn=0 at a HCLK edge, set HREADYOUT=1, HRESP=0, SRAMCS0=0, SRAMWEN=0, buffer valid=0, error FSM=IDLE, and clear pending data-phase state.
REQ-017 SHALL discard any uncommitted buffered write and any in-flight transfer when reset is applied mid-operation.

Structure
REQ-018 SHALL take the HTRANS/HSIZE encodings, the default DEPTH and the error-FSM state type from the shared AHB package.
REQ-019 SHALL implement the write buffer, including the address-compare and lane-merge logic, as a sub-module named ahb_sram_wbuf.

Verification
REQ-020 SHALL pass a bench covering these directed scenarios:
- Word write 0x0000_0010 = 0xDEADBEEF, then read the same address -> HRDATA=0xDEADBEEF; no wait states.
- Back-to-back write 0x20 = 0x11223344 and read 0x20 -> write is buffered, read returns 0x11223344 via merge, and the commit occurs in the next free cycle.
- Byte write 0xAA to 0x31 over word 0x30 = 0x00000000, with an immediate read of 0x30 -> HRDATA=0x0000AA00.
- Read of 0x0000_3000 (word 3072) -> two-cycle ERROR, and SRAMCS0 stays 0 throughout.
- Halfword at 0x41 -> ERROR; a following valid read at 0x40 -> OKAY with correct data.
- Reset asserted while the buffer is valid -> after reset valid=0, and a read of that address returns the old SRAM contents.
